regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (write-enable, 3-bit address, 16-bit data) between two writeback sources: the pipeline WB stage and the multi-cycle unit (multiply/divide).
- Fixed priority goes to WB. A starvation counter forces a multi-cycle grant after MAX_WAIT consecutive losses.
- Outputs are registered and drive the register file write port directly. Writes to r0 are filtered here.

---
 rtl/regfile_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, and a starvation counter forces a multi-cycle grant.
// Define REGWB_ARB_STATS_EN to add the saturating conflict and forced-grant counters.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 3,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_Wb_Valid,
    input  logic [REG_W-1:0]  i_Wb_Reg,
    input  logic [DATA_W-1:0] i_Wb_Data,
    output logic              o_Wb_Ready,
    input  logic              i_Mc_Valid,
    input  logic [REG_W-1:0]  i_Mc_Reg,
    input  logic [DATA_W-1:0] i_Mc_Data,
    output logic              o_Mc_Ready,
    output logic              o_RegWrite,
    output logic [REG_W-1:0]  o_Write_Register,
    output logic [DATA_W-1:0] o_Write_Data,
`ifdef REGWB_ARB_STATS_EN
    output logic [15:0]       o_Conflict_Count,
    output logic [15:0]       o_Force_Count,
`endif
    output logic              o_Zero_Drop
);

    localparam logic [0:0] PRI_WB = 1'b0;
    localparam logic [0:0] PRI_MC = 1'b1;
    localparam logic [3:0] MAX_W  = 4'(MAX_WAIT);

    logic [0:0]        state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              regwrite_q, regwrite_d;
    logic              zero_drop_q, zero_drop_d;
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              wb_grant, mc_grant, accept;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_data;

    // Grants are suppressed while reset is held so nothing is acknowledged during reset.
    always_comb begin
        wb_grant = 1'b0;
        mc_grant = 1'b0;
        if (rst_n) begin
            case (state_q)
                PRI_WB: begin
                    wb_grant = i_Wb_Valid;
                    mc_grant = !i_Wb_Valid && i_Mc_Valid;
                end
                PRI_MC:  mc_grant = i_Mc_Valid;
                default: mc_grant = 1'b0;
            endcase
        end
    end

    assign o_Wb_Ready = wb_grant;
    assign o_Mc_Ready = mc_grant;
    assign accept     = wb_grant || mc_grant;
    assign sel_reg    = wb_grant ? i_Wb_Reg  : i_Mc_Reg;
    assign sel_data   = wb_grant ? i_Wb_Data : i_Mc_Data;

    always_comb begin
        wait_d = wait_q;
        if (mc_grant || !i_Mc_Valid || state_q == PRI_MC)
            wait_d = 4'd0;
        else if (wait_q != MAX_W)
            wait_d = wait_q + 4'd1;

        // PRI_MC lasts exactly one cycle: it either grants Mc or drops back on a protocol violation.
        state_d = PRI_WB;
        if (state_q == PRI_WB && i_Mc_Valid && !mc_grant && wait_d == MAX_W)
            state_d = PRI_MC;

        regwrite_d   = accept && (sel_reg != '0);
        zero_drop_d  = accept && (sel_reg == '0);
        write_reg_d  = regwrite_d ? sel_reg  : write_reg_q;
        write_data_d = regwrite_d ? sel_data : write_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PRI_WB;
            wait_q       <= 4'd0;
            regwrite_q   <= 1'b0;
            zero_drop_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            regwrite_q   <= regwrite_d;
            zero_drop_q  <= zero_drop_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign o_RegWrite       = regwrite_q;
    assign o_Zero_Drop      = zero_drop_q;
    assign o_Write_Register = write_reg_q;
    assign o_Write_Data     = write_data_q;

`ifdef REGWB_ARB_STATS_EN
    logic [15:0] conflict_q, conflict_d;
    logic [15:0] force_q, force_d;

    always_comb begin
        conflict_d = conflict_q;
        force_d    = force_q;
        if (i_Wb_Valid && i_Mc_Valid && conflict_q != 16'hFFFF)
            conflict_d = conflict_q + 16'd1;
        if (mc_grant && state_q == PRI_MC && force_q != 16'hFFFF)
            force_d = force_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 16'd0;
            force_q    <= 16'd0;
        end else begin
            conflict_q <= conflict_d;
            force_q    <= force_d;
        end
    end

    assign o_Conflict_Count = conflict_q;
    assign o_Force_Count    = force_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a loss-counting reference model predicts grants and register writes.
module tb_regfile_wb_arbiter;
    localparam int DATA_W   = 16;
    localparam int REG_W    = 3;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_Wb_Valid = 1'b0;
    logic [REG_W-1:0]  i_Wb_Reg = '0;
    logic [DATA_W-1:0] i_Wb_Data = '0;
    logic              o_Wb_Ready;
    logic              i_Mc_Valid = 1'b0;
    logic [REG_W-1:0]  i_Mc_Reg = '0;
    logic [DATA_W-1:0] i_Mc_Data = '0;
    logic              o_Mc_Ready;
    logic              o_RegWrite;
    logic [REG_W-1:0]  o_Write_Register;
    logic [DATA_W-1:0] o_Write_Data;
    logic              o_Zero_Drop;
`ifdef REGWB_ARB_STATS_EN
    logic [15:0]       o_Conflict_Count;
    logic [15:0]       o_Force_Count;
`endif

    regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_Wb_Valid(i_Wb_Valid), .i_Wb_Reg(i_Wb_Reg), .i_Wb_Data(i_Wb_Data), .o_Wb_Ready(o_Wb_Ready),
        .i_Mc_Valid(i_Mc_Valid), .i_Mc_Reg(i_Mc_Reg), .i_Mc_Data(i_Mc_Data), .o_Mc_Ready(o_Mc_Ready),
        .o_RegWrite(o_RegWrite), .o_Write_Register(o_Write_Register), .o_Write_Data(o_Write_Data),
`ifdef REGWB_ARB_STATS_EN
        .o_Conflict_Count(o_Conflict_Count), .o_Force_Count(o_Force_Count),
`endif
        .o_Zero_Drop(o_Zero_Drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                zero;
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } exp_t;

    exp_t              exp_q[$];
    int                n_chk = 0;
    int                n_fail = 0;
    int                losses = 0;
    int                m_conflict = 0;
    int                m_force = 0;
    logic [REG_W-1:0]  last_reg = '0;
    logic [DATA_W-1:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: Mc is forced once it has lost MAX_WAIT cycles in a row.
    task automatic drive_cycle(input bit wv, input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] wd,
                               input bit mv, input logic [REG_W-1:0] mr, input logic [DATA_W-1:0] md,
                               output bit wg, output bit mg);
        bit forced;
        @(negedge clk);
        i_Wb_Valid = wv; i_Wb_Reg = wr; i_Wb_Data = wd;
        i_Mc_Valid = mv; i_Mc_Reg = mr; i_Mc_Data = md;
        #1;
        forced = (losses >= MAX_WAIT);
        wg = wv && !forced;
        mg = mv && (forced || !wv);
        check("wb_ready", {31'd0, o_Wb_Ready}, {31'd0, wg});
        check("mc_ready", {31'd0, o_Mc_Ready}, {31'd0, mg});
        if (wg || mg) begin
            exp_t e;
            e.r = wg ? wr : mr;
            e.d = wg ? wd : md;
            e.zero = (e.r == 0);
            exp_q.push_back(e);
            if (!e.zero) begin
                last_reg = e.r;
                last_data = e.d;
            end
        end
        if (wv && mv && m_conflict < 65535) m_conflict++;
        if (mg && forced && m_force < 65535) m_force++;
        if (mg || !mv) losses = 0;
        else if (losses < MAX_WAIT) losses++;
    endtask

    task automatic idle(input int n);
        bit wg, mg;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, wg, mg);
    endtask

    // Monitor: compares every presented write or r0 drop against the scoreboard head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (o_RegWrite && o_Zero_Drop) begin
                    check("write_and_drop_together", 32'd1, 32'd0);
                end else if (o_RegWrite || o_Zero_Drop) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", {31'd0, o_RegWrite}, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("zero_drop", {31'd0, o_Zero_Drop}, {31'd0, e.zero});
                        if (!e.zero) begin
                            check("write_reg", {29'd0, o_Write_Register}, {29'd0, e.r});
                            check("write_data", {16'd0, o_Write_Data}, {16'd0, e.d});
                        end
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        check("missing_write", 32'd0, 32'd1);
                    end
                    check("hold_reg", {29'd0, o_Write_Register}, {29'd0, last_reg});
                    check("hold_data", {16'd0, o_Write_Data}, {16'd0, last_data});
                end
            end
        end
    end

    initial begin
        bit wg, mg;
        bit wv, mv;
        logic [REG_W-1:0] wr, mr;
        logic [DATA_W-1:0] wd, md;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Write, then reset mid-cycle with WB still requesting.
        drive_cycle(1, 3'd6, 16'h4321, 0, 0, 0, wg, mg);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_regwrite", {31'd0, o_RegWrite}, 32'd0);
        check("rst_reg", {29'd0, o_Write_Register}, 32'd0);
        check("rst_data", {16'd0, o_Write_Data}, 32'd0);
        check("rst_zero_drop", {31'd0, o_Zero_Drop}, 32'd0);
        check("rst_wb_ready", {31'd0, o_Wb_Ready}, 32'd0);
        i_Wb_Valid = 1'b0;
        exp_q.delete();
        losses = 0; m_conflict = 0; m_force = 0;
        last_reg = '0; last_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive_cycle(1, 3'd3, 16'h1234, 0, 0, 0, wg, mg);
        idle(1);

        // Starvation: WB streams new data, Mc holds r5 until forced.
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 3'(i + 1), 16'h1000 + 16'(i), 1, 3'd5, 16'hBEEF, wg, mg);
        check("starve_forced_mc", {30'd0, wg, mg}, 32'd1);
        drive_cycle(1, 3'd4, 16'h1003, 0, 0, 0, wg, mg);
        idle(2);
`ifdef REGWB_ARB_STATS_EN
        check("stats_conflict", {16'd0, o_Conflict_Count}, 32'd4);
        check("stats_force", {16'd0, o_Force_Count}, 32'd1);
`endif

        // Priority, r0 drop, back-to-back Mc.
        drive_cycle(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'h5555, wg, mg);
        check("prio_wb_wins", {30'd0, wg, mg}, 32'd2);
        drive_cycle(0, 0, 0, 1, 3'd2, 16'h5555, wg, mg);
        idle(1);
        drive_cycle(1, 3'd0, 16'hFFFF, 0, 0, 0, wg, mg);
        idle(2);
        for (int i = 1; i <= 4; i++)
            drive_cycle(0, 0, 0, 1, 3'(i), 16'hC000 + 16'(i), wg, mg);
        idle(2);

        // Random traffic; a source keeps its request stable until granted.
        wv = 0; mv = 0; wr = 0; mr = 0; wd = 0; md = 0;
        wg = 0; mg = 0;
        for (int c = 0; c < 400; c++) begin
            if (!wv || wg) begin
                wv = ($urandom_range(0, 99) < 65);
                wr = 3'($urandom_range(0, 7));
                wd = 16'($urandom);
            end
            if (!mv || mg) begin
                mv = ($urandom_range(0, 99) < 55);
                mr = 3'($urandom_range(0, 7));
                md = 16'($urandom);
            end
            drive_cycle(wv, wr, wd, mv, mr, md, wg, mg);
        end
        idle(3);
`ifdef REGWB_ARB_STATS_EN
        check("stats_conflict_rand", {16'd0, o_Conflict_Count}, 32'(m_conflict));
        check("stats_force_rand", {16'd0, o_Force_Count}, 32'(m_force));
`endif
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
